// File: rtl/weight_fifo_loader.sv
// weight_fifo_loader
//   Splits 16-bit weight pairs into two 8-bit column FIFOs and pops rows from
//   both columns into the array on request.
//
//   Ports:
//     clk, reset                 clock and asynchronous active-high reset
//     in_valid/in_ready/in_data  weight word handshake ([7:0]=col0, [15:8]=col1)
//     load_req/load_rows         single-cycle request to pop 1..4 rows
//     push_col0/push_col1        push strobes, data_out carries the byte
//     pop                        pop strobe to both columns
//     occ0/occ1                  column occupancy, 0..4
//     load_busy/load_done/load_err  status: busy, completion pulse, reject pulse
//
//   Build option: LOADER_SKEW_DRAIN_EN adds a one-cycle DRAIN state after the
//   last pop so the column-1 skew register empties before load_done.
module weight_fifo_loader (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        load_req,
  input  logic [2:0]  load_rows,
  output logic        push_col0,
  output logic        push_col1,
  output logic [7:0]  data_out,
  output logic        pop,
  output logic [2:0]  occ0,
  output logic [2:0]  occ1,
  output logic        load_busy,
  output logic        load_done,
  output logic        load_err
);

`ifdef LOADER_SKEW_DRAIN_EN
  typedef enum logic [2:0] {StIdle, StPush0, StPush1, StPop, StDrain} state_e;
`else
  typedef enum logic [2:0] {StIdle, StPush0, StPush1, StPop} state_e;
`endif

  state_e      r_state;
  logic [15:0] r_word;
  logic [2:0]  r_rows;
  logic [2:0]  r_occ0;
  logic [2:0]  r_occ1;
  logic        r_push0;
  logic        r_push1;
  logic        r_pop;
  logic [7:0]  r_data;
  logic        r_busy;
  logic        r_done;
  logic        r_err;

  logic        w_in_ready;
  logic        w_rows_ok;

  assign w_in_ready = (r_state == StIdle) & ~load_req & (r_occ0 < 3'd4) & (r_occ1 < 3'd4);

  // Both columns must hold enough rows; 0 and 5..7 are illegal row counts.
  assign w_rows_ok = (load_rows != 3'd0) && (load_rows <= 3'd4) &&
                     (r_occ0 >= load_rows) && (r_occ1 >= load_rows);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_word  <= '0;
      r_rows  <= '0;
      r_occ0  <= '0;
      r_occ1  <= '0;
      r_push0 <= 1'b0;
      r_push1 <= 1'b0;
      r_pop   <= 1'b0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      // Occupancy follows the strobes driven this cycle.
      r_occ0 <= r_occ0 + {2'b00, r_push0} - {2'b00, r_pop};
      r_occ1 <= r_occ1 + {2'b00, r_push1} - {2'b00, r_pop};

      unique case (r_state)
        StIdle: begin
          if (load_req) begin
            if (w_rows_ok) begin
              r_rows  <= load_rows;
              r_pop   <= 1'b1;
              r_busy  <= 1'b1;
              r_state <= StPop;
            end else begin
              r_err <= 1'b1;
            end
          end else if (in_valid && w_in_ready) begin
            r_word  <= in_data;
            r_data  <= in_data[7:0];
            r_push0 <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= StPush0;
          end
        end
        StPush0: begin
          r_push0 <= 1'b0;
          r_push1 <= 1'b1;
          r_data  <= r_word[15:8];
          r_state <= StPush1;
        end
        StPush1: begin
          r_push1 <= 1'b0;
          r_data  <= '0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        StPop: begin
          if (r_rows == 3'd1) begin
            r_pop  <= 1'b0;
            r_rows <= '0;
`ifdef LOADER_SKEW_DRAIN_EN
            r_state <= StDrain;
`else
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= StIdle;
`endif
          end else begin
            r_rows <= r_rows - 3'd1;
          end
        end
`ifdef LOADER_SKEW_DRAIN_EN
        StDrain: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= StIdle;
        end
`endif
        default: begin
          r_push0 <= 1'b0;
          r_push1 <= 1'b0;
          r_pop   <= 1'b0;
          r_data  <= '0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign push_col0 = r_push0;
  assign push_col1 = r_push1;
  assign pop       = r_pop;
  assign data_out  = r_data;
  assign occ0      = r_occ0;
  assign occ1      = r_occ1;
  assign load_busy = r_busy;
  assign load_done = r_done;
  assign load_err  = r_err;

endmodule

// File: tb/tb_weight_fifo_loader.sv
// Bench for weight_fifo_loader: directed scenarios plus random traffic, all
// checked against a timeline model (scheduled strobes per future cycle).
module tb_weight_fifo_loader;

  localparam int NCYC = 4096;
`ifdef LOADER_SKEW_DRAIN_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        load_req;
  logic [2:0]  load_rows;
  logic        push_col0;
  logic        push_col1;
  logic [7:0]  data_out;
  logic        pop;
  logic [2:0]  occ0;
  logic [2:0]  occ1;
  logic        load_busy;
  logic        load_done;
  logic        load_err;

  weight_fifo_loader dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .load_req  (load_req),
    .load_rows (load_rows),
    .push_col0 (push_col0),
    .push_col1 (push_col1),
    .data_out  (data_out),
    .pop       (pop),
    .occ0      (occ0),
    .occ1      (occ1),
    .load_busy (load_busy),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Timeline model: expected strobes per absolute cycle index.
  bit       e_push0 [NCYC];
  bit       e_push1 [NCYC];
  bit       e_pop   [NCYC];
  bit       e_busy  [NCYC];
  bit       e_done  [NCYC];
  bit       e_err   [NCYC];
  bit [7:0] e_data  [NCYC];
  int cyc = 0;
  int free_at = 0;
  int m_occ0 = 0;
  int m_occ1 = 0;

  task automatic clear_from(input int from);
    for (int j = from; j < from + 16 && j < NCYC; j++) begin
      e_push0[j] = 0; e_push1[j] = 0; e_pop[j] = 0;
      e_busy[j] = 0; e_done[j] = 0; e_err[j] = 0; e_data[j] = 8'h00;
    end
  endtask

  // One clock cycle: drive inputs, compare at negedge, advance model.
  task automatic run_cycle(input logic v, input logic [15:0] d, input logic lr,
                           input logic [2:0] rows);
    logic       idle;
    logic       exp_rdy;
    logic [6:0] got_v;
    logic [6:0] exp_v;
    int t;
    int n;
    in_valid = v; in_data = d; load_req = lr; load_rows = rows;
    @(negedge clk);
    t = cyc;
    if (t + 8 >= NCYC) begin
      $display("FAIL cycle_budget got=%0d limit=%0d", t, NCYC);
      $fatal(1, "cycle budget exhausted");
    end
    idle = (t >= free_at);
    exp_rdy = idle && !lr && (m_occ0 < 4) && (m_occ1 < 4);
    got_v = {in_ready, push_col0, push_col1, pop, load_busy, load_done, load_err};
    exp_v = {exp_rdy, e_push0[t], e_push1[t], e_pop[t], e_busy[t], e_done[t], e_err[t]};
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL ctrl cyc=%0d {rdy,p0,p1,pop,busy,done,err} got=%b exp=%b", t, got_v, exp_v);
    end
    total++;
    if (data_out !== e_data[t]) begin
      bad++;
      $display("FAIL data_out cyc=%0d got=%h exp=%h", t, data_out, e_data[t]);
    end
    total++;
    if (occ0 !== 3'(m_occ0) || occ1 !== 3'(m_occ1)) begin
      bad++;
      $display("FAIL occ cyc=%0d got=%0d/%0d exp=%0d/%0d", t, occ0, occ1, m_occ0, m_occ1);
    end
    n = int'(push_col0) + int'(push_col1) + int'(pop);
    total++;
    if (n > 1) begin
      bad++;
      $display("FAIL strobe_excl cyc=%0d got=%0d exp<=1", t, n);
    end
    if (idle && lr) begin
      if (rows >= 1 && rows <= 4 && m_occ0 >= int'(rows) && m_occ1 >= int'(rows)) begin
        for (int k = 1; k <= int'(rows); k++) e_pop[t + k] = 1;
        for (int k = 1; k <= int'(rows) + EXTRA; k++) e_busy[t + k] = 1;
        e_done[t + int'(rows) + 1 + EXTRA] = 1;
        free_at = t + int'(rows) + 1 + EXTRA;
      end else begin
        e_err[t + 1] = 1;
      end
    end else if (exp_rdy && v) begin
      e_push0[t + 1] = 1; e_data[t + 1] = d[7:0];
      e_push1[t + 2] = 1; e_data[t + 2] = d[15:8];
      e_busy[t + 1] = 1; e_busy[t + 2] = 1;
      free_at = t + 3;
    end
    @(posedge clk);
    #1;
    m_occ0 = m_occ0 + int'(e_push0[t]) - int'(e_pop[t]);
    m_occ1 = m_occ1 + int'(e_push1[t]) - int'(e_pop[t]);
    cyc++;
    in_valid = 1'b0; load_req = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 16'h0000, 1'b0, 3'd0);
  endtask

  // Asynchronous reset from mid-cycle; outputs must clear without a clock edge.
  task automatic test_reset();
    in_valid = 1'b0; load_req = 1'b0;
    reset = 1'b1;
    #1;
    total++;
    if ({push_col0, push_col1, pop, load_busy, load_done, load_err} !== 6'b0) begin
      bad++;
      $display("FAIL reset_strobes got=%b exp=000000",
               {push_col0, push_col1, pop, load_busy, load_done, load_err});
    end
    total++;
    if (data_out !== 8'h00) begin
      bad++;
      $display("FAIL reset_data got=%h exp=00", data_out);
    end
    total++;
    if (occ0 !== 3'd0 || occ1 !== 3'd0) begin
      bad++;
      $display("FAIL reset_occ got=%0d/%0d exp=0/0", occ0, occ1);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    clear_from(cyc);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc++;
    m_occ0 = 0; m_occ1 = 0;
    free_at = cyc;
  endtask

  task automatic test_push_pair();
    run_cycle(1'b1, 16'hB2A1, 1'b0, 3'd0);
    total++;
    if (push_col0 !== 1'b1 || data_out !== 8'hA1) begin
      bad++;
      $display("FAIL pair_col0 got=%b/%h exp=1/a1", push_col0, data_out);
    end
    idle_cycles(1);
    total++;
    if (push_col1 !== 1'b1 || data_out !== 8'hB2) begin
      bad++;
      $display("FAIL pair_col1 got=%b/%h exp=1/b2", push_col1, data_out);
    end
    idle_cycles(1);
    total++;
    if (occ0 !== 3'd1 || occ1 !== 3'd1) begin
      bad++;
      $display("FAIL pair_occ got=%0d/%0d exp=1/1", occ0, occ1);
    end
  endtask

  task automatic test_fill();
    test_reset();
    for (int i = 0; i < 12; i++) run_cycle(1'b1, 16'($urandom), 1'b0, 3'd0);
    total++;
    if (occ0 !== 3'd4 || occ1 !== 3'd4 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL fill_full got=%0d/%0d rdy=%b exp=4/4 rdy=0", occ0, occ1, in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      run_cycle(1'b1, 16'($urandom), 1'b0, 3'd0);
      total++;
      if (push_col0 !== 1'b0 || occ0 !== 3'd4) begin
        bad++;
        $display("FAIL fill_fifth got=%b/%0d exp=0/4", push_col0, occ0);
      end
    end
  endtask

  task automatic test_load();
    run_cycle(1'b0, 16'h0000, 1'b1, 3'd3);
    for (int k = 1; k <= 3; k++) begin
      total++;
      if (pop !== 1'b1) begin
        bad++;
        $display("FAIL load_pop k=%0d got=%b exp=1", k, pop);
      end
      idle_cycles(1);
    end
    total++;
    if (pop !== 1'b0 || occ0 !== 3'd1 || occ1 !== 3'd1 || load_done !== (EXTRA == 0)) begin
      bad++;
      $display("FAIL load_end got=pop%b occ%0d/%0d done%b exp=pop0 occ1/1 done%0d",
               pop, occ0, occ1, load_done, EXTRA == 0);
    end
    if (EXTRA != 0) begin
      idle_cycles(1);
      total++;
      if (load_done !== 1'b1) begin
        bad++;
        $display("FAIL load_done_drain got=%b exp=1", load_done);
      end
    end
    idle_cycles(1);
  endtask

  task automatic test_load_err();
    run_cycle(1'b1, 16'h5A3C, 1'b0, 3'd0);
    idle_cycles(3);
    run_cycle(1'b0, 16'h0000, 1'b1, 3'd3);
    total++;
    if (load_err !== 1'b1 || pop !== 1'b0 || occ0 !== 3'd2) begin
      bad++;
      $display("FAIL err_rows3 got=err%b pop%b occ%0d exp=err1 pop0 occ2", load_err, pop, occ0);
    end
    run_cycle(1'b0, 16'h0000, 1'b1, 3'd0);
    total++;
    if (load_err !== 1'b1) begin
      bad++;
      $display("FAIL err_rows0 got=%b exp=1", load_err);
    end
    run_cycle(1'b0, 16'h0000, 1'b1, 3'd5);
    total++;
    if (load_err !== 1'b1 || occ1 !== 3'd2) begin
      bad++;
      $display("FAIL err_rows5 got=err%b occ%0d exp=err1 occ2", load_err, occ1);
    end
    idle_cycles(1);
  endtask

  task automatic test_priority();
    in_valid = 1'b1; in_data = 16'h7711; load_req = 1'b1; load_rows = 3'd2;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL prio_ready got=%b exp=0", in_ready);
    end
    run_cycle(1'b1, 16'h7711, 1'b1, 3'd2);
    total++;
    if (pop !== 1'b1 || push_col0 !== 1'b0) begin
      bad++;
      $display("FAIL prio_load got=pop%b push%b exp=pop1 push0", pop, push_col0);
    end
    idle_cycles(3);
    total++;
    if (occ0 !== 3'd0 || occ1 !== 3'd0) begin
      bad++;
      $display("FAIL prio_occ got=%0d/%0d exp=0/0", occ0, occ1);
    end
  endtask

  task automatic test_reset_mid_pop();
    for (int i = 0; i < 12; i++) run_cycle(1'b1, 16'($urandom), 1'b0, 3'd0);
    run_cycle(1'b0, 16'h0000, 1'b1, 3'd4);
    idle_cycles(1);
    total++;
    if (pop !== 1'b1) begin
      bad++;
      $display("FAIL midpop_pre got=%b exp=1", pop);
    end
    test_reset();
    for (int i = 0; i < 6; i++) begin
      idle_cycles(1);
      total++;
      if (load_done !== 1'b0 || load_busy !== 1'b0) begin
        bad++;
        $display("FAIL midpop_after got=done%b busy%b exp=0 0", load_done, load_busy);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      run_cycle(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 5) == 0),
                3'($urandom_range(0, 7)));
    end
    idle_cycles(8);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = '0; load_req = 1'b0; load_rows = '0;
    test_reset();
    test_push_pair();
    test_fill();
    test_load();
    test_load_err();
    test_priority();
    test_reset_mid_pop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
